// File: rtl/modexp_sequencer.sv
// Modular exponentiation sequencer: result = base^exp mod m, right-to-left
// square-and-multiply. Every WxW product is handed to the downstream modulus
// reduction block as a 2W-bit request; only one request is outstanding at a time.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start_in
// RED_ISSUE | issue the initial reduction of the base
// RED_WAIT  | waiting for the reduced base
// MUL_ISSUE | issue accumulator * base
// MUL_WAIT  | waiting for the reduced product into the accumulator
// STEP      | shift the exponent, decide whether more bits remain
// SQR_ISSUE | issue base * base
// SQR_WAIT  | waiting for the reduced square into the base
// DONE      | present result_out with a one-cycle valid_out pulse
module modexp_sequencer #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic [WIDTH-1:0]       base_in,
    input  logic [EXP_WIDTH-1:0]   exp_in,
    input  logic [WIDTH-1:0]       modulus_in,
    output logic [WIDTH-1:0]       result_out,
    output logic                   busy_out,
    output logic                   valid_out,
    output logic                   mod_ready_out,
    output logic [2*WIDTH-1:0]     mod_value_out,
    output logic [WIDTH-1:0]       mod_modulus_out,
    input  logic                   mod_valid_in,
    input  logic [WIDTH-1:0]       mod_result_in
);

    typedef enum logic [3:0] {
        IDLE,
        RED_ISSUE,
        RED_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        STEP,
        SQR_ISSUE,
        SQR_WAIT,
        DONE
    } state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       base_q;
    logic [WIDTH-1:0]       acc_q;
    logic [WIDTH-1:0]       mod_q;
    logic [WIDTH-1:0]       result_q;
    logic [EXP_WIDTH-1:0]   exp_q;
    logic                   busy_q;
    logic                   valid_q;
    logic                   ready_q;
    logic [2*WIDTH-1:0]     value_q;

    logic [2*WIDTH-1:0]     mul_prod_d;
    logic [2*WIDTH-1:0]     sqr_prod_d;
    logic [EXP_WIDTH-1:0]   exp_shift_d;
    logic [WIDTH-1:0]       acc_init_d;

    // Full-width products: operands are zero-extended so nothing is truncated.
    assign mul_prod_d  = {{WIDTH{1'b0}}, acc_q}  * {{WIDTH{1'b0}}, base_q};
    assign sqr_prod_d  = {{WIDTH{1'b0}}, base_q} * {{WIDTH{1'b0}}, base_q};
    assign exp_shift_d = exp_q >> 1;
    // 1 mod m is 0 when m==1, so the accumulator already starts reduced.
    assign acc_init_d  = (modulus_in == WIDTH'(1)) ? '0 : WIDTH'(1);

    assign result_out      = result_q;
    assign busy_out        = busy_q;
    assign valid_out       = valid_q;
    assign mod_ready_out   = ready_q;
    assign mod_value_out   = value_q;
    assign mod_modulus_out = mod_q;

    // Sequencer FSM with all outputs registered; reset also drops any pending reply.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            base_q   <= '0;
            acc_q    <= '0;
            mod_q    <= '0;
            result_q <= '0;
            exp_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
            value_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        base_q <= base_in;
                        exp_q  <= exp_in;
                        mod_q  <= modulus_in;
                        busy_q <= 1'b1;
                        if (modulus_in == '0) begin
                            acc_q   <= '0;
                            state_q <= DONE;
                        end else if (exp_in == '0) begin
                            acc_q   <= acc_init_d;
                            state_q <= DONE;
                        end else begin
                            acc_q   <= acc_init_d;
                            state_q <= RED_ISSUE;
                        end
                    end
                end
                RED_ISSUE: begin
                    value_q <= {{WIDTH{1'b0}}, base_q};
                    ready_q <= 1'b1;
                    state_q <= RED_WAIT;
                end
                RED_WAIT, SQR_WAIT: begin
                    if (mod_valid_in) begin
                        base_q  <= mod_result_in;
                        state_q <= exp_q[0] ? MUL_ISSUE : STEP;
                    end
                end
                MUL_ISSUE: begin
                    value_q <= mul_prod_d;
                    ready_q <= 1'b1;
                    state_q <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (mod_valid_in) begin
                        acc_q   <= mod_result_in;
                        state_q <= STEP;
                    end
                end
                STEP: begin
                    exp_q   <= exp_shift_d;
                    state_q <= (exp_shift_d == '0) ? DONE : SQR_ISSUE;
                end
                SQR_ISSUE: begin
                    value_q <= sqr_prod_d;
                    ready_q <= 1'b1;
                    state_q <= SQR_WAIT;
                end
                DONE: begin
                    result_q <= acc_q;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_sequencer.sv
// Bench for modexp_sequencer: a behavioural reduction responder with variable
// latency, and a scoreboard that checks every valid_out against queued results.
module tb_modexp_sequencer;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic [15:0] base_in;
    logic [15:0] exp_in;
    logic [15:0] modulus_in;
    logic [15:0] result_out;
    logic        busy_out;
    logic        valid_out;
    logic        mod_ready_out;
    logic [31:0] mod_value_out;
    logic [15:0] mod_modulus_out;
    logic        mod_valid_in;
    logic [15:0] mod_result_in;

    int          checks    = 0;
    int          errors    = 0;
    int          req_cnt   = 0;
    int          valid_cnt = 0;
    int          lat_cfg   = 0;
    logic [15:0] sb_q[$];

    always #5 clk = ~clk;

    modexp_sequencer #(.WIDTH(16), .EXP_WIDTH(16)) dut (
        .clk_in          (clk),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .base_in         (base_in),
        .exp_in          (exp_in),
        .modulus_in      (modulus_in),
        .result_out      (result_out),
        .busy_out        (busy_out),
        .valid_out       (valid_out),
        .mod_ready_out   (mod_ready_out),
        .mod_value_out   (mod_value_out),
        .mod_modulus_out (mod_modulus_out),
        .mod_valid_in    (mod_valid_in),
        .mod_result_in   (mod_result_in)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_modexp(input logic [15:0] b, input logic [15:0] e,
                                               input logic [15:0] m);
        longint unsigned r, bb, mm;
        if (m == 16'd0) return 16'd0;
        mm = longint'(m);
        r  = 1 % mm;
        bb = longint'(b) % mm;
        for (int i = 0; i < 16; i++) begin
            if (e[i]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
        end
        return 16'(r);
    endfunction

    function automatic int ref_reqs(input logic [15:0] e, input logic [15:0] m);
        int pop, msb;
        if (m == 16'd0 || e == 16'd0) return 0;
        pop = 0;
        msb = 0;
        for (int i = 0; i < 16; i++) begin
            if (e[i]) begin
                pop++;
                msb = i;
            end
        end
        return 1 + pop + msb;
    endfunction

    // Reduction responder: answers each request after a delay, checks the request holds.
    initial begin
        logic [31:0] v;
        logic [15:0] m;
        int          lat;
        bit          aborted;
        mod_valid_in  = 1'b0;
        mod_result_in = '0;
        forever begin
            @(negedge clk);
            if (mod_ready_out && !rst_in) begin
                req_cnt++;
                v       = mod_value_out;
                m       = mod_modulus_out;
                lat     = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 3));
                aborted = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (rst_in) aborted = 1'b1;
                    if (!aborted) begin
                        check("value_stable", 64'(mod_value_out), 64'(v));
                        check("no_ready_outstanding", 64'(mod_ready_out), 64'd0);
                    end
                end
                mod_result_in = (m == 16'd0) ? 16'd0 : 16'(v % {16'd0, m});
                mod_valid_in  = 1'b1;
                @(negedge clk);
                mod_valid_in  = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every valid_out pops one expected result.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (valid_out) begin
                valid_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 64'(result_out), 64'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("result", 64'(result_out), 64'(e));
                end
            end
        end
    end

    task automatic run_op(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                          input logic [15:0] res, input int nreq,
                          input bit timing_chk, input bit glitch);
        int r0, v0, t;
        r0 = req_cnt;
        v0 = valid_cnt;
        @(posedge clk); #1;
        base_in    = b;
        exp_in     = e;
        modulus_in = m;
        start_in   = 1'b1;
        sb_q.push_back(res);
        @(negedge clk);
        @(posedge clk); #1;
        start_in   = 1'b0;
        base_in    = 16'($urandom);
        exp_in     = 16'($urandom);
        modulus_in = 16'($urandom);
        @(negedge clk);
        if (timing_chk) begin
            check("busy_cycle1", 64'(busy_out), 64'd1);
            check("valid_cycle1", 64'(valid_out), 64'd0);
            @(negedge clk);
            check("valid_cycle2", 64'(valid_out), 64'd1);
            check("busy_cycle2", 64'(busy_out), 64'd0);
        end
        if (glitch) begin
            repeat (2) @(posedge clk);
            #1;
            check("busy_at_glitch", 64'(busy_out), 64'd1);
            base_in    = 16'd99;
            exp_in     = 16'd5;
            modulus_in = 16'd13;
            start_in   = 1'b1;
            @(posedge clk); #1;
            start_in   = 1'b0;
        end
        t = 0;
        while (valid_cnt == v0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (valid_cnt == v0) begin
            check("done_timeout", 64'd0, 64'd1);
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
        check("valid_once", 64'(valid_cnt - v0), 64'd1);
        check("req_count", 64'(req_cnt - r0), 64'(nreq));
        check("busy_idle", 64'(busy_out), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          r0, v0, t, busy_seen;
        logic [15:0] b, e, m;
        rst_in     = 1'b1;
        start_in   = 1'b0;
        base_in    = '0;
        exp_in     = '0;
        modulus_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_in = 1'b0;
        @(negedge clk);
        check("rst_result", 64'(result_out), 64'd0);
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_ready", 64'(mod_ready_out), 64'd0);
        check("rst_value", 64'(mod_value_out), 64'd0);
        check("rst_modulus", 64'(mod_modulus_out), 64'd0);

        run_op(16'd4,  16'd13, 16'd497, 16'd445, 7, 1'b0, 1'b0);
        run_op(16'd10, 16'd3,  16'd7,   16'd6,   4, 1'b0, 1'b1);
        run_op(16'd3,  16'd0,  16'd7,   16'd1,   0, 1'b1, 1'b0);
        run_op(16'd5,  16'd9,  16'd1,   16'd0,   6, 1'b0, 1'b0);
        run_op(16'd4,  16'd13, 16'd497, 16'd445, 7, 1'b0, 1'b0);
        run_op(16'd5,  16'd9,  16'd0,   16'd0,   0, 1'b0, 1'b0);
        run_op(16'd4,  16'd13, 16'd497, 16'd445, 7, 1'b0, 1'b0);

        // Abort in MUL_WAIT: the reply arrives after reset and must be ignored.
        lat_cfg = 6;
        r0 = req_cnt;
        @(posedge clk); #1;
        base_in    = 16'd4;
        exp_in     = 16'd13;
        modulus_in = 16'd497;
        start_in   = 1'b1;
        @(posedge clk); #1;
        start_in   = 1'b0;
        t = 0;
        while (req_cnt < r0 + 2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("reach_mul_wait", 64'(req_cnt - r0), 64'd2);
        @(posedge clk); #1;
        rst_in = 1'b1;
        @(posedge clk); #1;
        rst_in = 1'b0;
        @(negedge clk);
        check("abort_result", 64'(result_out), 64'd0);
        check("abort_busy", 64'(busy_out), 64'd0);
        check("abort_valid", 64'(valid_out), 64'd0);
        check("abort_ready", 64'(mod_ready_out), 64'd0);
        check("abort_value", 64'(mod_value_out), 64'd0);
        check("abort_modulus", 64'(mod_modulus_out), 64'd0);
        v0 = valid_cnt;
        busy_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy_out || mod_ready_out) busy_seen++;
        end
        check("late_reply_ignored", 64'(busy_seen), 64'd0);
        check("late_no_valid", 64'(valid_cnt - v0), 64'd0);
        lat_cfg = 0;
        run_op(16'd10, 16'd3, 16'd7, 16'd6, 4, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            b = 16'($urandom);
            e = 16'($urandom);
            m = 16'($urandom);
            if (i % 4 == 0) m = 16'($urandom_range(0, 20));
            if (i % 8 == 1) e = 16'($urandom_range(0, 3));
            run_op(b, e, m, ref_modexp(b, e, m), ref_reqs(e, m), 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
